// File: rtl/audio_sample_accumulator.sv
// Multichannel PCM sample collector with a fill bank and a published bank.
// Banks are handed to the clk_pixel side with a ready/take toggle pair.
module audio_sample_accumulator #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int CHANNELS = 2,
    parameter int MAX_SAMPLES_PER_PACKET = 4,
    localparam int DEPTH = (CHANNELS == 2) ? MAX_SAMPLES_PER_PACKET : 1
) (
    input  logic                                clk_audio,
    input  logic                                audio_buffer_rst,
    input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] audio_sample_word,
    input  logic                                sample_valid,
    input  logic                                take_toggle,
    output logic [DEPTH*CHANNELS*24-1:0]        bank_word,
    output logic [3:0]                          bank_present,
    output logic [2:0]                          bank_count,
    output logic                                bank_ready_toggle,
    output logic [2:0]                          fill_level,
    output logic [7:0]                          overflow_count
);

    localparam int SW = CHANNELS * AUDIO_BIT_WIDTH;
    localparam int LW = CHANNELS * 24;
    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    typedef enum logic {FREE, PUBLISHED} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           fill_q [DEPTH];
    logic [SW-1:0]           fill_d [DEPTH];
    logic [2:0]              fill_level_q, fill_level_d;
    logic [DEPTH*LW-1:0]     bank_word_q, bank_word_d;
    logic [2:0]              bank_count_q, bank_count_d;
    logic                    ready_q, ready_d;
    logic [7:0]              ovf_q, ovf_d;
    logic                    s1_q, s2_q, s3_q;
    logic                    ack;
    logic                    publish;

    assign ack     = s2_q ^ s3_q;
    assign publish = (state_q == FREE) && (fill_level_q != 3'd0);

    always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
        if (audio_buffer_rst) state_q <= FREE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FREE:      if (publish) state_d = PUBLISHED;
            PUBLISHED: if (ack)     state_d = FREE;
        endcase
    end

    always_comb begin
        fill_d       = fill_q;
        fill_level_d = fill_level_q;
        bank_word_d  = bank_word_q;
        bank_count_d = bank_count_q;
        ready_d      = ready_q;
        ovf_d        = ovf_q;
        if (publish) begin
            for (int k = 0; k < DEPTH; k++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    bank_word_d[k*LW + c*24 +: 24] =
                        24'(fill_q[k][c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
                end
            end
            bank_count_d = fill_level_q;
            ready_d      = ~ready_q;
            // coincident sample starts the next bank, never joins this one
            fill_level_d = {2'b00, sample_valid};
            if (sample_valid) fill_d[0] = audio_sample_word;
        end else if (sample_valid) begin
            if (fill_level_q < DEPTH_L) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (3'(k) == fill_level_q) fill_d[k] = audio_sample_word;
                end
                fill_level_d = fill_level_q + 3'd1;
            end else if (ovf_q != 8'hFF) begin
                ovf_d = ovf_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
        if (audio_buffer_rst) begin
            for (int k = 0; k < DEPTH; k++) fill_q[k] <= '0;
            fill_level_q <= '0;
            bank_word_q  <= '0;
            bank_count_q <= '0;
            ready_q      <= 1'b0;
            ovf_q        <= '0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            fill_level_q <= fill_level_d;
            bank_word_q  <= bank_word_d;
            bank_count_q <= bank_count_d;
            ready_q      <= ready_d;
            ovf_q        <= ovf_d;
            s1_q         <= take_toggle;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
        end
    end

    always_comb begin
        bank_present = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bank_present[k] = (3'(k) < bank_count_q);
        end
    end

    assign bank_word         = bank_word_q;
    assign bank_count        = bank_count_q;
    assign bank_ready_toggle = ready_q;
    assign fill_level        = fill_level_q;
    assign overflow_count    = ovf_q;

endmodule

// File: tb/tb_audio_sample_accumulator.sv
// Bench for audio_sample_accumulator: queue-based bank model plus
// an 8-channel single-sample instance for the saturating overflow path.
module tb_audio_sample_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, sv_a, take_a;
    logic [31:0]  word_a;
    logic [191:0] bank_a;
    logic [3:0]   pres_a;
    logic [2:0]   cnt_a, lvl_a;
    logic         rdy_a;
    logic [7:0]   ovf_a;

    logic         rst_b, sv_b, take_b;
    logic [191:0] word_b, bank_b;
    logic [3:0]   pres_b;
    logic [2:0]   cnt_b, lvl_b;
    logic         rdy_b;
    logic [7:0]   ovf_b;

    audio_sample_accumulator #(
        .AUDIO_BIT_WIDTH(16), .CHANNELS(2), .MAX_SAMPLES_PER_PACKET(4)
    ) u_a (
        .clk_audio(clk), .audio_buffer_rst(rst_a),
        .audio_sample_word(word_a), .sample_valid(sv_a),
        .take_toggle(take_a), .bank_word(bank_a),
        .bank_present(pres_a), .bank_count(cnt_a),
        .bank_ready_toggle(rdy_a), .fill_level(lvl_a),
        .overflow_count(ovf_a)
    );

    audio_sample_accumulator #(
        .AUDIO_BIT_WIDTH(24), .CHANNELS(8), .MAX_SAMPLES_PER_PACKET(4)
    ) u_b (
        .clk_audio(clk), .audio_buffer_rst(rst_b),
        .audio_sample_word(word_b), .sample_valid(sv_b),
        .take_toggle(take_b), .bank_word(bank_b),
        .bank_present(pres_b), .bank_count(cnt_b),
        .bank_ready_toggle(rdy_b), .fill_level(lvl_b),
        .overflow_count(ovf_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    bit          m_pub, m_tog;
    int          m_cnt, m_ovf;
    logic [31:0] m_fill[$];
    logic [31:0] m_bank[$];
    bit          hist[$];

    task automatic model_reset();
        m_pub = 0; m_tog = 0; m_cnt = 0; m_ovf = 0;
        m_fill.delete(); m_bank.delete();
        hist = '{0, 0, 0};
    endtask

    task automatic model_edge();
        bit ack;
        ack = hist[hist.size()-2] ^ hist[hist.size()-3];
        if (!m_pub && m_fill.size() > 0) begin
            m_bank = m_fill;
            m_cnt  = m_fill.size();
            m_tog  = !m_tog;
            m_pub  = 1;
            m_fill.delete();
            if (sv_a) m_fill.push_back(word_a);
        end else begin
            if (m_pub && ack) m_pub = 0;
            if (sv_a) begin
                if (m_fill.size() < 4) m_fill.push_back(word_a);
                else if (m_ovf < 255) m_ovf++;
            end
        end
        hist.push_back(take_a);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic compare_a();
        logic [191:0] e_bank, msk;
        logic [3:0]   pres;
        e_bank = '0; msk = '0; pres = '0;
        for (int k = 0; k < m_cnt; k++) begin
            e_bank[k*48 +: 48] = {8'h00, m_bank[k][31:16], 8'h00, m_bank[k][15:0]};
            msk[k*48 +: 48] = '1;
            pres[k] = 1'b1;
        end
        check("bank", 256'(bank_a & msk), 256'(e_bank));
        check("count", 256'(cnt_a), 256'(m_cnt));
        check("present", 256'(pres_a), 256'(pres));
        check("ready", 256'(rdy_a), 256'(m_tog));
        check("fill", 256'(lvl_a), 256'(m_fill.size()));
        check("ovf", 256'(ovf_a), 256'(m_ovf));
    endtask

    task automatic cyc(input logic v, input logic [31:0] w, input logic t);
        sv_a = v; word_a = w; take_a = t;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_a();
    endtask

    initial begin
        logic [31:0]  wa, wb1;
        logic [191:0] w0, wb;
        int           guard, e_ovf;

        rst_a = 1'b1; sv_a = 1'b0; take_a = 1'b0; word_a = '0;
        rst_b = 1'b1; sv_b = 1'b0; take_b = 1'b0; word_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bank", 256'(bank_a), 256'(0));
        check("rst_b_bank", 256'(bank_b), 256'(0));
        compare_a();
        rst_a = 1'b0; rst_b = 1'b0;

        cyc(1'b1, 32'h5678_1234, 1'b0);
        check("basic_lvl1", 256'(lvl_a), 256'(1));
        cyc(1'b0, 32'h0, 1'b0);
        check("basic_lanes", 256'(bank_a[47:0]), 256'(48'h005678_001234));
        check("basic_rdy", 256'(rdy_a), 256'(1));
        check("basic_pres", 256'(pres_a), 256'(4'b0001));

        for (int i = 0; i < 6; i++) cyc(1'b1, $urandom, 1'b0);
        check("full_lvl", 256'(lvl_a), 256'(4));
        check("full_ovf", 256'(ovf_a), 256'(2));
        repeat (3) cyc(1'b0, 32'h0, 1'b1);
        check("ack3_rdy", 256'(rdy_a), 256'(1));
        cyc(1'b0, 32'h0, 1'b1);
        check("ack4_cnt", 256'(cnt_a), 256'(4));
        check("ack4_pres", 256'(pres_a), 256'(4'b1111));

        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        wa = $urandom; wb1 = $urandom;
        cyc(1'b1, wa, 1'b0);
        cyc(1'b1, wb1, 1'b0);
        check("coinc_cnt", 256'(cnt_a), 256'(1));
        check("coinc_lvl", 256'(lvl_a), 256'(1));
        check("coinc_lane", 256'(bank_a[47:0]),
              256'({8'h00, wa[31:16], 8'h00, wa[15:0]}));

        for (int i = 0; i < 1500; i++) begin
            logic t;
            t = take_a;
            if (take_a != m_tog && $urandom_range(0, 3) == 0) t = m_tog;
            cyc(1'($urandom_range(0, 1)), $urandom, t);
        end

        guard = 0;
        while (!(!m_pub && m_fill.size() == 0) && guard < 40) begin
            cyc(1'b0, 32'h0, m_tog);
            guard++;
        end
        check("drain_timeout", 256'(guard < 40), 256'(1));
        cyc(1'b1, $urandom, take_a);
        cyc(1'b0, 32'h0, take_a);
        repeat (3) cyc(1'b1, $urandom, take_a);
        check("pre_rst_lvl", 256'(lvl_a), 256'(3));
        #2;
        rst_a = 1'b1; take_a = 1'b0; sv_a = 1'b0;
        #1;
        check("mid_rst_bank", 256'(bank_a), 256'(0));
        check("mid_rst_cnt", 256'(cnt_a), 256'(0));
        check("mid_rst_pres", 256'(pres_a), 256'(0));
        check("mid_rst_lvl", 256'(lvl_a), 256'(0));
        check("mid_rst_rdy", 256'(rdy_a), 256'(0));
        check("mid_rst_ovf", 256'(ovf_a), 256'(0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) cyc(1'b0, 32'h0, 1'b1);
        check("stale_rdy", 256'(rdy_a), 256'(0));
        cyc(1'b1, $urandom, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        check("post_rst_pub", 256'(rdy_a), 256'(1));

        w0 = '0;
        for (int k = 1; k <= 300; k++) begin
            for (int j = 0; j < 6; j++) wb[j*32 +: 32] = $urandom;
            if (k == 1) w0 = wb;
            word_b = wb; sv_b = 1'b1;
            @(posedge clk);
            @(negedge clk);
            e_ovf = (k <= 2) ? 0 : ((k - 2 > 255) ? 255 : k - 2);
            if (k inside {1, 2, 3, 10, 200, 257, 258, 300}) begin
                check("l1_lvl", 256'(lvl_b), 256'(1));
                check("l1_ovf", 256'(ovf_b), 256'(e_ovf));
                check("l1_cnt", 256'(cnt_b), 256'((k == 1) ? 0 : 1));
                check("l1_pres", 256'(pres_b), 256'((k == 1) ? 0 : 1));
                check("l1_rdy", 256'(rdy_b), 256'((k == 1) ? 0 : 1));
                if (k >= 2) check("l1_bank", 256'(bank_b), 256'(w0));
            end
        end
        sv_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_accumulator.md
# audio_sample_accumulator

Clock-domain-side audio sample buffer for the HDMI transmitter. It collects multichannel PCM samples on `clk_audio` into a fill bank and publishes full or partial banks to a stable output bank. A toggle handshake hands each bank across to the `clk_pixel` packet logic, so publishing never loses samples in flight. It generalises the two-channel, reset-cleared buffer to 2–8 channels, selectable depth, per-sample strobes, back-pressure and overflow accounting.

## Interface
- `AUDIO_BIT_WIDTH`, 16: sample width, 16..24; zero-extended at MSBs to 24 bits on output.
- `CHANNELS`, 2: channel count, one of 2/4/6/8.
- `MAX_SAMPLES_PER_PACKET`, 4: samples per bank when CHANNELS==2, 1..4. Localparam `DEPTH` = CHANNELS==2 ? MAX_SAMPLES_PER_PACKET : 1 (layout 1 carries one sample).
- `clk_audio` in 1: audio sample clock; all state is in this domain.
- `audio_buffer_rst` in 1: reset, asynchronous, active-high; clock `clk_audio`.
- `audio_sample_word` in CHANNELS*AUDIO_BIT_WIDTH: one sample across all channels, channel 0 at LSBs.
- `sample_valid` in 1: capture strobe, one sample per high cycle.
- `take_toggle` in 1: `clk_pixel`-domain acknowledge; each toggle means the published bank is consumed.
- `bank_word` out DEPTH*CHANNELS*24: published bank, sample k at bits [k*CHANNELS*24 +: CHANNELS*24].
- `bank_present` out 4: bit k = (k < bank_count); bits ≥ DEPTH are 0.
- `bank_count` out 3: samples in published bank, 1..DEPTH while published.
- `bank_ready_toggle` out 1: toggles once per publish.
- `fill_level` out 3: samples in fill bank, 0..DEPTH.
- `overflow_count` out 8: dropped samples, saturating at 255.

## Operation
- State machine has two states:
  - FREE: no bank owned by the consumer.
  - PUBLISHED: the consumer owns `bank_word`.
- Capture: when `sample_valid` is high and fill_level < DEPTH, write the sample to slot fill_level and increment fill_level.
- Publish happens when state==FREE and fill_level ≥ 1. On that edge:
  - copy the fill bank to `bank_word`.
  - set `bank_count` = fill_level and toggle `bank_ready_toggle`.
  - move to PUBLISHED.
  - set fill_level to 0, or to 1 with the new sample in slot 0 if `sample_valid` is high on the same edge. The sample coincident with a publish is never included in the published bank.
- Ack path:
  - `take_toggle` passes through a two-flop synchronizer (s1, s2) plus a delay flop s3.
  - ack = s2 ^ s3.
  - ack in PUBLISHED moves to FREE. Ack in FREE is ignored.
- Overflow: when `sample_valid` is high, fill_level==DEPTH and no publish occurs on that edge:
  - drop the sample.
  - increment `overflow_count` unless it is already 255.
  - leave fill bank contents unchanged.
- Padding: each 24-bit output lane = {(24-AUDIO_BIT_WIDTH) zeros, sample}. Unused present bits are constant 0.
- Output stability: `bank_word`, `bank_count` and `bank_present` change only on a publish edge. They are stable throughout PUBLISHED.
- Consumer rule: the consumer samples the bank only after detecting a `bank_ready_toggle` edge through its own synchronizer. It toggles `take_toggle` only after its last read.

## Timing
- Reset (async assert, release synchronous to `clk_audio`):
  - state FREE.
  - fill_level 0, bank_count 0, bank_present 0, `bank_word` 0.
  - `bank_ready_toggle` 0, `overflow_count` 0.
  - s1/s2/s3 0.
- The `clk_pixel` reset generator of `audio_buffer_rst` also clears the consumer's toggle copies and `take_toggle`.
- Reset mid-operation discards both banks. Any ack edge arriving in FREE after reset is ignored.
- Capture latency: `sample_valid` at edge N makes fill_level visible after edge N. The earliest publish is edge N+1.
- Ack latency: after a `take_toggle` change, FREE is reached on the 3rd `clk_audio` edge. The earliest republish is the 4th edge.
- Minimum one cycle in FREE is not required: publish is evaluated on the registered FREE state on the cycle after the ack.
- fill_level never exceeds DEPTH. `bank_count` is never 0 while PUBLISHED.
- `take_toggle` may toggle at most once per `bank_ready_toggle` edge. Extra toggles in FREE have no effect.

## Test plan
- Basic publish (CHANNELS=2, DEPTH=4, width 16): one `sample_valid` with L=16'h1234, R=16'h5678 -> next edge: bank_count=1, bank_present=4'b0001, lane0=24'h001234, lane1=24'h005678, `bank_ready_toggle` 0→1, fill_level 0.
- Fill while published: hold in PUBLISHED and send 4 samples -> fill_level=4. A 5th and 6th sample -> overflow_count=2, fill_level=4. Toggle `take_toggle` -> FREE on the 3rd edge, publish on the 4th with bank_count=4, present=4'b1111.
- Coincident sample and publish: sample at edge N (FREE), another at N+1 -> published bank_count=1 containing the first sample only; fill_level=1 holding the second.
- Layout 1 (CHANNELS=8, width 24): `sample_valid` every cycle with `take_toggle` never toggled -> first sample published, fill_level=1, overflow_count increments by 1 each further cycle and saturates at 255.
- Reset mid-operation: assert `audio_buffer_rst` while PUBLISHED with fill_level=3 -> all outputs immediately 0, state FREE. A stale `take_toggle` edge after release causes no state change.
